pwm_cap_core: RTL

- PWM capture/measurement engine: samples an external PWM waveform and measures its period and high time in prescaled clock ticks.
- Publishes each completed measurement on a valid/ready result port.
- Receive-side counterpart to the team's APB4 PWM generator. Intended to sit behind an APB4 register wrapper, which maps ctrl, pscr, result and status.

---
 rtl/pwm_cap_core.sv | 113 +++++++++++
 1 files changed

// File: rtl/pwm_cap_core.sv
// pwm_cap_core: measures period and high time of an external PWM input in prescaled ticks
module pwm_cap_core #(
    parameter int CNT_WIDTH   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] pscr_i,
    input  logic                 pwm_i,
    input  logic                 clr_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic [CNT_WIDTH-1:0] high_o,
    output logic                 res_ovf_o,
    output logic                 overrun_o,
    output logic                 busy_o
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_RISE = 2'd1;
    localparam logic [1:0] MEAS_HIGH = 2'd2;
    localparam logic [1:0] MEAS_LOW  = 2'd3;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES:0]   sync_ext;
    logic                   s_d_q;
    logic [1:0]             state_q, state_d;
    logic [CNT_WIDTH-1:0]   pre_cnt_q, pre_cnt_d, per_cnt_q, per_cnt_d, high_cnt_q, high_cnt_d;
    logic [CNT_WIDTH-1:0]   period_q, period_d, high_q, high_d;
    logic                   ovf_q, ovf_d, valid_q, valid_d, res_ovf_q, res_ovf_d, overrun_q, overrun_d;
    logic                   s, rise, fall, active, tick, high_inc, per_sat, high_sat;
    logic                   publish, drop, load;

    assign sync_ext = {sync_q, pwm_i};
    assign sync_d   = sync_ext[SYNC_STAGES-1:0];
    assign s        = sync_q[SYNC_STAGES-1];
    assign rise     = s & ~s_d_q;
    assign fall     = ~s & s_d_q;
    assign active   = en_i && state_q != IDLE;
    assign tick     = active && !rise && pre_cnt_q == pscr_i;
    assign high_inc = tick && state_q == MEAS_HIGH && !fall;
    assign per_sat  = per_cnt_q == CNT_MAX;
    assign high_sat = high_cnt_q == CNT_MAX;
    assign publish  = en_i && state_q == MEAS_LOW && rise;
    assign drop     = publish && valid_q && !res_ready_i;
    assign load     = publish && !drop;

    // Prescaler, measurement counters, overflow tracking and result/flag next-state
    always_comb begin
        pre_cnt_d  = (!active || rise || tick) ? '0 : pre_cnt_q + CNT_ONE;
        per_cnt_d  = !active ? '0 : rise ? CNT_ONE : (tick && !per_sat) ? per_cnt_q + CNT_ONE : per_cnt_q;
        high_cnt_d = !active ? '0 : rise ? CNT_ONE : (high_inc && !high_sat) ? high_cnt_q + CNT_ONE : high_cnt_q;
        ovf_d      = (!active || rise) ? 1'b0 : ovf_q | (tick && per_sat) | (high_inc && high_sat);
        valid_d    = load | (valid_q & ~res_ready_i);
        period_d   = load ? per_cnt_q : period_q;
        high_d     = load ? high_cnt_q : high_q;
        res_ovf_d  = load ? ovf_q : res_ovf_q;
        overrun_d  = drop | (overrun_q & ~clr_i);
    end

    // Capture FSM; dropping enable always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = WAIT_RISE;
            WAIT_RISE: if (rise) state_d = MEAS_HIGH;
            MEAS_HIGH: if (fall) state_d = MEAS_LOW;
            default:   if (rise) state_d = MEAS_HIGH;
        endcase
        if (!en_i) state_d = IDLE;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q     <= '0;
            s_d_q      <= 1'b0;
            state_q    <= IDLE;
            pre_cnt_q  <= '0;
            per_cnt_q  <= '0;
            high_cnt_q <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            period_q   <= '0;
            high_q     <= '0;
            res_ovf_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            s_d_q      <= s;
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            per_cnt_q  <= per_cnt_d;
            high_cnt_q <= high_cnt_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            period_q   <= period_d;
            high_q     <= high_d;
            res_ovf_q  <= res_ovf_d;
            overrun_q  <= overrun_d;
        end
    end

    assign res_valid_o = valid_q;
    assign period_o    = period_q;
    assign high_o      = high_q;
    assign res_ovf_o   = res_ovf_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = state_q != IDLE;
endmodule
